// File: rtl/vga_scan_out.sv
// Purpose : raster scan driver; presents x/y to a renderer, registers returned rgb plus aligned syncs to the VGA DAC.
// Latency : outputs for pixel (X,Y) update PIPE+1 pixel ticks after x=X, y=Y is presented; frame_tick is a 1-clock strobe.
// Backpressure: none; free-running raster, the renderer must meet the PIPE-tick contract.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   x, y, active           current raster position (19-bit, unmasked) and visible-area flag
//   rgb                    renderer colour {R,G,B}, valid at the tick edge PIPE ticks after its coordinate
//   vga_r/g/b, hsync, vsync, blank_n   registered DAC outputs, mutually aligned
//   pix_tick               one-clock strobe per pixel boundary
//   frame_tick             one-clock pulse when the raster enters vertical blanking
module vga_scan_out #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE     = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] x,
    output logic [18:0] y,
    output logic        active,
    input  logic [23:0] rgb,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        pix_tick,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A 1-bit divider is kept even for CLK_DIV = 1; it then sits at 0 and
    // pix_tick stays permanently high.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [18:0] X_LAST     = 19'(H_TOTAL - 1);
    localparam logic [18:0] Y_LAST     = 19'(V_TOTAL - 1);
    localparam logic [18:0] X_ACT_END  = 19'(H_ACTIVE);
    localparam logic [18:0] Y_ACT_END  = 19'(V_ACTIVE);
    localparam logic [18:0] Y_ACT_LAST = 19'(V_ACTIVE - 1);
    localparam logic [18:0] HS_BEGIN   = 19'(H_ACTIVE + H_FP);
    localparam logic [18:0] HS_END     = 19'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [18:0] VS_BEGIN   = 19'(V_ACTIVE + V_FP);
    localparam logic [18:0] VS_END     = 19'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line entries are {hs, vs, act}; reset fill is "idle, blanked".
    localparam logic [2:0] DLY_IDLE = 3'b110;

    logic [DIV_W-1:0]     div_q;
    logic                 raw_hs;
    logic                 raw_vs;
    logic [PIPE-1:0][2:0] dly_q;
    logic [23:0]          rgb_q;
    logic                 dly_hs;
    logic                 dly_vs;
    logic                 dly_act;

    // ---------------------------------------------------------------
    // Pixel-clock divider
    // ---------------------------------------------------------------
    assign pix_tick = (div_q == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
        end else if (pix_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (pix_tick) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? 19'd0 : y + 19'd1;
            end else begin
                x <= x + 19'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage-0 decode from the presented coordinate
    // ---------------------------------------------------------------
    assign active = (x < X_ACT_END) && (y < Y_ACT_END);
    assign raw_hs = !((x >= HS_BEGIN) && (x < HS_END));
    assign raw_vs = !((y >= VS_BEGIN) && (y < VS_END));

    // ---------------------------------------------------------------
    // Sync/active delay line, PIPE ticks deep
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                dly_q[i] <= DLY_IDLE;
            end
        end else if (pix_tick) begin
            dly_q[0] <= {raw_hs, raw_vs, active};
            for (int i = 1; i < PIPE; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign {dly_hs, dly_vs, dly_act} = dly_q[PIPE-1];

    // ---------------------------------------------------------------
    // Colour capture. The renderer's answer for a pixel is valid at the
    // tick edge PIPE ticks after its coordinate, one tick before the
    // delayed syncs reach the output stage, so it is held here for one
    // tick to land on the same edge as hsync/vsync/blank_n.
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q <= '0;
        end else if (pix_tick) begin
            rgb_q <= rgb;
        end
    end

    // ---------------------------------------------------------------
    // Output register: all DAC-side signals change on the same edge.
    // Colour is forced black outside the visible area.
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else if (pix_tick) begin
            hsync   <= dly_hs;
            vsync   <= dly_vs;
            blank_n <= dly_act;
            if (dly_act) begin
                {vga_r, vga_g, vga_b} <= rgb_q;
            end else begin
                {vga_r, vga_g, vga_b} <= 24'h000000;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame tick: high during the clock in which the counters read
    // (0, V_ACTIVE), i.e. registered from the advance that produces it.
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_tick && (x == X_LAST) && (y == Y_ACT_LAST);
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Purpose : randomized scoreboard bench for vga_scan_out on a scaled-down raster.
// Latency : expects DAC outputs PIPE+1 ticks after each coordinate, frame_tick on entry to (0, V_ACTIVE).
// Backpressure: none; the bench plays the renderer with a (PIPE-1)-tick delayed colour stream.
module tb_vga_scan_out;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 10;
    localparam int H_FP     = 3;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int PIPE     = 3;

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] col;
    } exp_t;

    localparam exp_t IDLE = {1'b1, 1'b1, 1'b0, 24'h000000};

    logic        clock;
    logic        reset;
    logic [18:0] x;
    logic [18:0] y;
    logic        active;
    logic [23:0] rgb;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        pix_tick;
    logic        frame_tick;

    vga_scan_out #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .PIPE    (PIPE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .active    (active),
        .rgb       (rgb),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank_n   (blank_n),
        .pix_tick  (pix_tick),
        .frame_tick(frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: pixel index since reset, coordinates derived by
    // division, expected output stream held in a queue whose PIPE
    // leading idle entries model the pipeline fill.
    // ---------------------------------------------------------------
    int          clk_cnt = 0;
    int          pix_n   = 0;
    int          mx      = 0;
    int          my      = 0;
    int          mod_ft  = 0;
    logic        in_reset = 1'b0;
    logic        exp_ft   = 1'b0;
    logic        exp_pt   = 1'b0;
    logic [23:0] rgb_next = 24'h0;
    exp_t        exp_q[$];
    logic [23:0] rend_q[$];

    function automatic exp_t pix_exp(input int px, input int py, input logic [23:0] c);
        exp_t e;
        logic act;
        act   = (px < H_ACTIVE) && (py < V_ACTIVE);
        e.hs  = !((px >= H_ACTIVE + H_FP) && (px < H_ACTIVE + H_FP + H_SYNC));
        e.vs  = !((py >= V_ACTIVE + V_FP) && (py < V_ACTIVE + V_FP + V_SYNC));
        e.bl  = act;
        e.col = act ? c : 24'h000000;
        return e;
    endfunction

    // Renderer + expectation for the pixel just presented.
    task automatic present();
        logic [23:0] c;
        c = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
        exp_q.push_back(pix_exp(mx, my, c));
        rend_q.push_back(c);
        if (rend_q.size() == PIPE) rgb_next = rend_q.pop_front();
    endtask

    initial begin
        forever begin
            @(posedge clock);
            exp_ft = 1'b0;
            if (reset === 1'b1) begin
                in_reset = 1'b1;
                clk_cnt  = 0;
                pix_n    = 0;
                mx       = 0;
                my       = 0;
                exp_q.delete();
                rend_q.delete();
                for (int i = 0; i < PIPE; i++) exp_q.push_back(IDLE);
                present();
            end else begin
                in_reset = 1'b0;
                clk_cnt++;
                if (clk_cnt % CLK_DIV == 0) begin
                    pix_n++;
                    mx = pix_n % H_TOTAL;
                    my = (pix_n / H_TOTAL) % V_TOTAL;
                    present();
                    if (mx == 0 && my == V_ACTIVE) begin
                        exp_ft = 1'b1;
                        mod_ft++;
                    end
                end
            end
            exp_pt = ((clk_cnt + 1) % CLK_DIV == 0);
            #1 rgb = rgb_next;
        end
    end

    // ---------------------------------------------------------------
    // Monitor: pops one expectation per DUT pixel boundary and checks
    // every clock that outputs hold the last expected value.
    // ---------------------------------------------------------------
    int ft_seen = 0;

    initial begin
        exp_t cur;
        logic prev_pt;
        logic started;
        int   cyc;
        int   restart_cyc;
        int   last_ft;
        cur = IDLE; prev_pt = 1'b0; started = 1'b0;
        cyc = 0; restart_cyc = 0; last_ft = -1;
        forever begin
            @(posedge clock);
            #2;
            cyc++;
            if (in_reset) begin
                cur         = IDLE;
                started     = 1'b1;
                restart_cyc = cyc;
                last_ft     = -1;
            end else if (started && prev_pt) begin
                if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
                else cur = exp_q.pop_front();
            end
            if (started) begin
                chk("x",          32'(x),                       32'(mx));
                chk("y",          32'(y),                       32'(my));
                chk("active",     32'(active),                  32'((mx < H_ACTIVE) && (my < V_ACTIVE)));
                chk("pix_tick",   32'(pix_tick),                32'(exp_pt));
                chk("frame_tick", 32'(frame_tick),              32'(exp_ft));
                chk("hsync",      32'(hsync),                   32'(cur.hs));
                chk("vsync",      32'(vsync),                   32'(cur.vs));
                chk("blank_n",    32'(blank_n),                 32'(cur.bl));
                chk("vga_rgb",    32'({vga_r, vga_g, vga_b}),   32'(cur.col));
                if (frame_tick === 1'b1) begin
                    ft_seen++;
                    if (last_ft < 0) chk("ft_first_gap", 32'(cyc - restart_cyc), 32'(H_TOTAL * V_ACTIVE * CLK_DIV));
                    else             chk("ft_period",    32'(cyc - last_ft),     32'(FRAME_CLK));
                    last_ft = cyc;
                end
            end
            @(negedge clock);
            prev_pt = pix_tick;
        end
    end

    // ---------------------------------------------------------------
    // Stimulus: reset, two-plus frames, mid-frame reset, two-plus frames.
    // ---------------------------------------------------------------
    initial begin
        bit found;
        reset = 1'b1;
        rgb   = 24'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        repeat (2 * FRAME_CLK + 37) @(negedge clock);

        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            if (mx == 7 && my == 3) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("midframe_position_reached", 32'(found), 32'd1);

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        repeat (2 * FRAME_CLK + FRAME_CLK / 2) @(negedge clock);

        chk("frame_tick_count", 32'(ft_seen), 32'(mod_ft));
        chk("frame_tick_seen",  32'(ft_seen >= 4), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
